attention_weight_stream_loader: RTL and testbench
=================================================

// Module: attention_weight_stream_loader
// PURPOSE
//  Writer end of the weight-parameter path. Accepts a valid/ready stream of weight beats and packs
//  PARALLELISM_DIM_0*PARALLELISM_DIM_1 words per beat into full rows of TENSOR_SIZE_DIM_0 words.
//  Writes each row into an on-chip RAM. Serves reads through the same addr0/ce0/q0 2-cycle port as
//  the existing weight ROMs, so a weight source can read it unchanged.
// PARAMETERS
//  TENSOR_SIZE_DIM_0   32   words per row (row width); must be a multiple of PARALLELISM_DIM_0
//  TENSOR_SIZE_DIM_1   576  number of rows (RAM depth)
//  PRECISION_0         16   word width in bits
//  PRECISION_1         3    fractional bits; carried through, no arithmetic
//  PARALLELISM_DIM_0   1    words per beat along dim 0
//  PARALLELISM_DIM_1   1    must be 1 (one row segment per beat)
//  BEATS_PER_ROW       TENSOR_SIZE_DIM_0/PARALLELISM_DIM_0 (derived)
//  AWIDTH              $clog2(TENSOR_SIZE_DIM_1)+1 (derived)
// PORTS
//  clk            in   1                          clock
//  rst            in   1                          synchronous, active-high reset
//  data_in        in   [PRECISION_0-1:0] x P0*P1  beat words; word j goes to row slot beat*P0+j
//  data_in_valid  in   1                          beat valid
//  data_in_ready  out  1                          high only in LOAD state
//  reload         in   1                          1-cycle pulse; in DONE, restarts loading at row 0
//  load_done      out  1                          high while all TENSOR_SIZE_DIM_1 rows are written
//  addr0          in   AWIDTH                     read row address
//  ce0            in   1                          read enable; advances both read pipeline stages
//  q0             out  PRECISION_0*TENSOR_SIZE_DIM_0  row data, word k at bits [16k+15:16k]
//  err            out  1                          sticky error flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=LOAD, beat_cnt=0, row_cnt=0, load_done=0, err=0, q0 pipeline regs=0.
//    RAM contents are not cleared.
//  - States: LOAD -> DONE when the last beat of row TENSOR_SIZE_DIM_1-1 is accepted.
//    DONE -> LOAD on reload (counters cleared in the same cycle). reload in LOAD is ignored.
//  - Accept = data_in_valid & data_in_ready. On accept, words go into the row assembly register
//    at offset beat_cnt*P0, and beat_cnt increments.
//  - On the accept with beat_cnt==BEATS_PER_ROW-1, the assembled row (including this beat) is
//    written to ram[row_cnt] in the same edge. beat_cnt wraps to 0 and row_cnt increments.
//  - load_done rises the cycle after the final write; data_in_ready falls in that same cycle.
//  - No accept occurs while data_in_valid=0. Counters hold across stalls.
//  - Read: when ce0=1, stage0<=ram[addr0] and q0<=stage0. Latency is 2 ce0-enabled edges.
//    When ce0=0 both stages hold.
//  - Read and write to the same row in the same edge: the read returns the old contents.
//  - Reset mid-load: the partially assembled row is discarded and loading restarts at row 0.
//  - Reads are permitted in any state. Reads of unwritten rows return stale RAM contents.
// CONFIGURATION
//  WEIGHT_LOADER_CHECK_EN defined:
//    err is set (sticky until rst) when any of these occurs:
//      - ce0=1 with addr0>=TENSOR_SIZE_DIM_1
//      - data_in_valid=1 while in DONE
//      - reload=1 while in LOAD
//    An out-of-range read returns 0 in q0.
//  WEIGHT_LOADER_CHECK_EN undefined: err is tied to 0. An out-of-range read returns don't-care.
// STRUCTURE
//  - Package attention_weight_loader_pkg holds:
//      - typedef enum logic {LOAD, DONE} loader_state_t
//      - a function computing beat slot offsets
//  - Sub-module attention_weight_loader_ram: 1 write port, 1 read port, 2-stage registered read
//    with ce0, read-first behaviour.
//  - Top holds the FSM, the counters, the row assembly register and the check logic.
// TESTING (bench: DIM_0=4, P0=2, DIM_1=3, PRECISION_0=16)
//  - Stream 6 beats {0x0001,0x0002},{0x0003,0x0004},... with valid held high:
//    the writes land on the 2nd, 4th and 6th accepts; load_done=1 the cycle after the 6th
//    accept; ready=0 from then on.
//  - After load, ce0=1, addr0=1: q0 equals 0x0008_0007_0006_0005 two edges later.
//    Toggling ce0=0 holds q0.
//  - Random valid gaps (30% idle) on the same stream: RAM contents are identical and
//    load_done rises exactly once.
//  - Assert rst after 3 beats, then stream 6 new beats {0x1xxx}: row 0 holds only new data,
//    and load_done rises after the 6th new beat.
//  - In DONE pulse reload, stream new data, and read row 0 while it is being written in the
//    same cycle: the read returns the old row; a later read returns the new row.
//  - CHECK_EN build: ce0 with addr0=3 sets err and q0=0; data_in_valid in DONE keeps err=1
//    until rst. Non-CHECK build: err stays 0.

Source files
------------

// File: rtl/attention_weight_loader_pkg.sv
// Shared types and helpers for the attention weight stream loader.
package attention_weight_loader_pkg;

    typedef enum logic {LOAD, DONE} loader_state_t;

    // First row slot filled by a given beat.
    function automatic int beat_slot_offset(input int beat, input int words_per_beat);
        return beat * words_per_beat;
    endfunction

endpackage

// File: rtl/attention_weight_loader_ram.sv
// Row-wide weight RAM: one write port, one ce0-gated 2-stage read port, read-first.
module attention_weight_loader_ram #(
    parameter int WIDTH  = 512,
    parameter int DEPTH  = 576,
    parameter int AWIDTH = 11,
    localparam int RAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RAW-1:0]    waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              ce0,
    input  logic [AWIDTH-1:0] addr0,
    output logic [WIDTH-1:0]  q0
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] stage0_q;
    logic [WIDTH-1:0] q0_q;
    logic             in_range;

    assign in_range = (addr0 < AWIDTH'(DEPTH));

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range addresses read as zero rather than aliasing onto a real row.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage0_q <= '0;
            q0_q     <= '0;
        end else if (ce0) begin
            stage0_q <= in_range ? mem[addr0[RAW-1:0]] : '0;
            q0_q     <= stage0_q;
        end
    end

    assign q0 = q0_q;

endmodule

// File: rtl/attention_weight_stream_loader.sv
// Packs a valid/ready weight beat stream into rows of an on-chip RAM read through addr0/ce0/q0.
// Optional input-misuse checking is enabled by defining WEIGHT_LOADER_CHECK_EN.
module attention_weight_stream_loader
    import attention_weight_loader_pkg::*;
#(
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int TENSOR_SIZE_DIM_1 = 576,
    parameter int PRECISION_0       = 16,
    parameter int PRECISION_1       = 3,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int PARALLELISM_DIM_1 = 1,
    localparam int BEATS_PER_ROW    = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
    localparam int AWIDTH           = $clog2(TENSOR_SIZE_DIM_1) + 1
) (
    input  logic                                                           clk,
    input  logic                                                           rst,
    input  logic [PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0][PRECISION_0-1:0] data_in,
    input  logic                                                           data_in_valid,
    output logic                                                           data_in_ready,
    input  logic                                                           reload,
    output logic                                                           load_done,
    input  logic [AWIDTH-1:0]                                              addr0,
    input  logic                                                           ce0,
    output logic [PRECISION_0*TENSOR_SIZE_DIM_0-1:0]                       q0,
    output logic                                                           err
);

    localparam int BW     = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int RAM_AW = (TENSOR_SIZE_DIM_1 > 1) ? $clog2(TENSOR_SIZE_DIM_1) : 1;
    localparam int ROW_W  = PRECISION_0 * TENSOR_SIZE_DIM_0;
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS_PER_ROW - 1);
    localparam logic [AWIDTH-1:0] LAST_ROW  = AWIDTH'(TENSOR_SIZE_DIM_1 - 1);

    // Empty marker block that appears in the elaborated hierarchy for unsupported shapes.
    if (PARALLELISM_DIM_1 != 1 || PRECISION_1 >= PRECISION_0 ||
        (TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0) != 0) begin : g_unsupported_params
    end

    loader_state_t                               state_q, state_d;
    logic [BW-1:0]                               beat_cnt_q, beat_cnt_d;
    logic [AWIDTH-1:0]                           row_cnt_q, row_cnt_d;
    logic [TENSOR_SIZE_DIM_0-1:0][PRECISION_0-1:0] row_q, row_d;
    logic                                        accept;
    logic                                        wr_en;

    assign data_in_ready = (state_q == LOAD);
    assign load_done     = (state_q == DONE);
    assign accept        = data_in_valid & data_in_ready;
    assign wr_en         = accept && (beat_cnt_q == LAST_BEAT);

    // Each row slot takes the lane of the current beat that maps onto it.
    for (genvar gi = 0; gi < TENSOR_SIZE_DIM_0; gi++) begin : g_slot
        localparam int LANE = gi % PARALLELISM_DIM_0;
        localparam int BASE = gi - LANE;
        logic hit;
        assign hit       = accept && (beat_slot_offset(int'(beat_cnt_q), PARALLELISM_DIM_0) == BASE);
        assign row_d[gi] = hit ? data_in[LANE] : row_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        row_q <= row_d;
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        row_cnt_d  = row_cnt_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        row_cnt_d  = row_cnt_q + AWIDTH'(1);
                        if (row_cnt_q == LAST_ROW) begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
                end
            end
            DONE: begin
                if (reload) begin
                    state_d    = LOAD;
                    beat_cnt_d = '0;
                    row_cnt_d  = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // The write carries row_d so the final beat of a row lands in the same edge.
    attention_weight_loader_ram #(
        .WIDTH (ROW_W),
        .DEPTH (TENSOR_SIZE_DIM_1),
        .AWIDTH(AWIDTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_en),
        .waddr(row_cnt_q[RAM_AW-1:0]),
        .wdata(row_d),
        .ce0  (ce0),
        .addr0(addr0),
        .q0   (q0)
    );

`ifdef WEIGHT_LOADER_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((ce0 && addr0 > LAST_ROW) ||
                     (data_in_valid && state_q == DONE) ||
                     (reload && state_q == LOAD)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_attention_weight_stream_loader.sv
// Directed-plus-random bench for attention_weight_stream_loader against a row-packing model.
module tb_attention_weight_stream_loader;

    localparam int D0  = 4;
    localparam int P0  = 2;
    localparam int D1  = 3;
    localparam int PW  = 16;
    localparam int AW  = $clog2(D1) + 1;
    localparam int BPR = D0 / P0;
    localparam int NB  = BPR * D1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [P0-1:0][PW-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic                  reload;
    logic                  load_done;
    logic [AW-1:0]         addr0;
    logic                  ce0;
    logic [PW*D0-1:0]      q0;
    logic                  err;

    always #5 clk = ~clk;

    attention_weight_stream_loader #(
        .TENSOR_SIZE_DIM_0(D0),
        .TENSOR_SIZE_DIM_1(D1),
        .PRECISION_0      (PW),
        .PRECISION_1      (3),
        .PARALLELISM_DIM_0(P0),
        .PARALLELISM_DIM_1(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .reload       (reload),
        .load_done    (load_done),
        .addr0        (addr0),
        .ce0          (ce0),
        .q0           (q0),
        .err          (err)
    );

    int          checks   = 0;
    int          failures = 0;
    logic        ld_prev  = 1'b0;
    int          ld_rises = 0;
    logic [PW-1:0]    words [NB][P0];
    logic [PW*D0-1:0] model [D1];
    logic [PW*D0-1:0] old_row0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (load_done && !ld_prev) ld_rises++;
        ld_prev = load_done;
    endtask

    // Beat b carries words for row b/BPR at slots (b%BPR)*P0 + j.
    task automatic build_model();
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < P0; j++) begin
                model[b / BPR][((b % BPR) * P0 + j) * PW +: PW] = words[b][j];
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_in_valid = 1'b0;
        reload = 1'b0;
        ce0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_beat(input int b, input int idle_pct);
        int guard;
        guard = 0;
        while (idle_pct > 0 && $urandom_range(99) < idle_pct && guard < 8) begin
            data_in_valid = 1'b0;
            tick();
            guard++;
        end
        for (int j = 0; j < P0; j++) data_in[j] = words[b][j];
        data_in_valid = 1'b1;
        guard = 0;
        while (!data_in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!data_in_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout beat=%0d observed=0 expected=1", b);
        end
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic read_row(input int r, input string tag);
        ce0 = 1'b1;
        addr0 = AW'(r);
        tick();
        tick();
        ce0 = 1'b0;
        check(tag, q0, model[r]);
    endtask

    initial begin
        data_in = '0;
        addr0 = '0;
        do_reset();
        check("rst_ready", 64'(data_in_ready), 64'd1);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_q0", q0, 64'd0);

        // Held-valid counting stream.
        for (int b = 0; b < NB; b++) begin
            words[b][0] = PW'(2 * b + 1);
            words[b][1] = PW'(2 * b + 2);
        end
        build_model();
        ld_rises = 0;
        for (int b = 0; b < NB; b++) begin
            send_beat(b, 0);
            check($sformatf("seq_load_done_b%0d", b), 64'(load_done), (b == NB - 1) ? 64'd1 : 64'd0);
        end
        check("seq_ready_after", 64'(data_in_ready), 64'd0);
        tick();
        tick();
        check("seq_ready_hold", 64'(data_in_ready), 64'd0);
        read_row(1, "seq_row1_model");
        check("seq_row1_const", q0, 64'h0008_0007_0006_0005);
        addr0 = '0;
        tick();
        tick();
        tick();
        check("seq_ce0_hold", q0, 64'h0008_0007_0006_0005);
        read_row(0, "seq_row0");
        read_row(2, "seq_row2");

        // Same stream with random idle gaps.
        do_reset();
        ld_rises = 0;
        for (int b = 0; b < NB; b++) begin
            send_beat(b, 30);
            if (b == NB - 2) check("gap_not_done_early", 64'(load_done), 64'd0);
        end
        for (int i = 0; i < 5; i++) tick();
        check("gap_load_done", 64'(load_done), 64'd1);
        check("gap_rises_once", 64'(ld_rises), 64'd1);
        for (int r = 0; r < D1; r++) read_row(r, $sformatf("gap_row%0d", r));

        // Reset mid-load, then a fresh stream.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            words[b][0] = PW'($urandom_range(16'h0fff));
            words[b][1] = PW'($urandom_range(16'h0fff));
            send_beat(b, 20);
        end
        do_reset();
        for (int b = 0; b < NB; b++) begin
            words[b][0] = 16'h1000 | PW'($urandom_range(16'h0fff));
            words[b][1] = 16'h1000 | PW'($urandom_range(16'h0fff));
        end
        build_model();
        for (int b = 0; b < NB; b++) begin
            send_beat(b, 20);
            if (b >= NB - 2)
                check($sformatf("mid_load_done_b%0d", b), 64'(load_done), (b == NB - 1) ? 64'd1 : 64'd0);
        end
        for (int r = 0; r < D1; r++) read_row(r, $sformatf("mid_row%0d", r));

        // Reload and read row 0 on the very edge that rewrites it.
        old_row0 = model[0];
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_ready", 64'(data_in_ready), 64'd1);
        check("reload_load_done", 64'(load_done), 64'd0);
        for (int b = 0; b < NB; b++) begin
            words[b][0] = PW'($urandom);
            words[b][1] = PW'($urandom);
        end
        build_model();
        send_beat(0, 0);
        for (int j = 0; j < P0; j++) data_in[j] = words[1][j];
        data_in_valid = 1'b1;
        ce0 = 1'b1;
        addr0 = '0;
        tick();
        data_in_valid = 1'b0;
        tick();
        check("rw_same_edge_old", q0, old_row0);
        tick();
        check("rw_later_new", q0, model[0]);
        ce0 = 1'b0;
        for (int b = 2; b < NB; b++) send_beat(b, 0);
        check("reload_done", 64'(load_done), 64'd1);
        read_row(1, "reload_row1");
        read_row(2, "reload_row2");

`ifdef WEIGHT_LOADER_CHECK_EN
        check("chk_err_clean", 64'(err), 64'd0);
        ce0 = 1'b1;
        addr0 = AW'(3);
        tick();
        check("chk_err_oor", 64'(err), 64'd1);
        tick();
        ce0 = 1'b0;
        check("chk_q0_oor_zero", q0, 64'd0);
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        tick();
        check("chk_err_sticky", 64'(err), 64'd1);
        do_reset();
        check("chk_err_cleared", 64'(err), 64'd0);
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("chk_err_reload_in_load", 64'(err), 64'd1);
        check("chk_reload_ignored", 64'(data_in_ready), 64'd1);
`else
        ce0 = 1'b1;
        addr0 = AW'(3);
        tick();
        tick();
        ce0 = 1'b0;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        check("nochk_load_done_kept", 64'(load_done), 64'd1);
        do_reset();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("nochk_reload_ignored", 64'(data_in_ready), 64'd1);
        check("nochk_err_zero", 64'(err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
